// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame scheduler: FSM encoding, requester id type, round-robin helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fft_ctrl_pkg;

    localparam int FFT_CTRL_ID_W = 1;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_LOAD  = 2'd1;
    localparam logic [1:0] FSM_START = 2'd2;
    localparam logic [1:0] FSM_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = FSM_IDLE,
        LOAD  = FSM_LOAD,
        START = FSM_START,
        DRAIN = FSM_DRAIN
    } fsm_state_t;

    typedef logic [FFT_CTRL_ID_W-1:0] req_id_t;

    // A contested pick goes to whichever requester was not served last.
    function automatic req_id_t rr_pick(input logic [1:0] req, input req_id_t last_id);
        req_id_t id;
        id = '0;
        case (req)
            2'b01:   id = 1'b0;
            2'b10:   id = 1'b1;
            2'b11:   id = ~last_id;
            default: id = '0;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/fft_rr_arb2.sv
// Two-way round-robin picker for whole-frame grants.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module fft_rr_arb2
    import fft_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic       gnt_valid,
    output req_id_t    gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = rr_pick(req, last_grant);
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Shares one fft core between two stream requesters, one whole frame per grant, results tagged by id.
// Latency: grant one cycle after tvalid seen idle; data paths combinational; start one cycle after last beat.
// Backpressure: tready passed straight through in LOAD/DRAIN; no buffering, so stalls hold the FSM in place.
module fft_frame_arbiter
    import fft_ctrl_pkg::*;
#(
    parameter int SIZE       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,

    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tlast,

    input  logic                  s01_axis_tvalid,
    output logic                  s01_axis_tready,
    input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                  s01_axis_tlast,

    output logic                  fft_axis_tvalid,
    input  logic                  fft_axis_tready,
    output logic [DATA_WIDTH-1:0] fft_axis_tdata,
    output logic                  fft_axis_tlast,

    output logic                  fft_start,

    input  logic                  fft_res_tvalid,
    output logic                  fft_res_tready,
    input  logic [DATA_WIDTH-1:0] fft_res_tdata,
    input  logic                  fft_res_tlast,

    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tdest,

    output logic                  busy,
    output logic                  err_len
);

    localparam int                CNT_W    = $clog2(SIZE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SIZE - 1);

    fsm_state_t        state_q,      state_d;
    req_id_t           grant_q,      grant_d;
    req_id_t           last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              err_len_q,    err_len_d;

    logic              arb_vld;
    req_id_t           arb_id;

    logic              sel_vld;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic              sel_last;
    logic              in_load;
    logic              in_drain;
    logic              beat_last;
    logic              in_acc;
    logic              res_acc;

    fft_rr_arb2 u_arb (
        .req        ({s01_axis_tvalid, s00_axis_tvalid}),
        .last_grant (last_grant_q),
        .gnt_valid  (arb_vld),
        .gnt_id     (arb_id)
    );

    always_comb begin
        sel_vld   = grant_q[0] ? s01_axis_tvalid : s00_axis_tvalid;
        sel_dat   = grant_q[0] ? s01_axis_tdata  : s00_axis_tdata;
        sel_last  = grant_q[0] ? s01_axis_tlast  : s00_axis_tlast;
        in_load   = (state_q == LOAD);
        in_drain  = (state_q == DRAIN);
        beat_last = (cnt_q == CNT_LAST);
        in_acc    = in_load && sel_vld && fft_axis_tready;
        res_acc   = in_drain && fft_res_tvalid && m00_axis_tready;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_len_d    = err_len_q;

        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_id;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_acc) begin
                    // Frame length is fixed at SIZE; tlast only feeds the error flag.
                    if (sel_last != beat_last) begin
                        err_len_d = 1'b1;
                    end
                    if (beat_last) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            START: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (res_acc && fft_res_tlast) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_len_q    <= err_len_d;
        end
    end

    always_comb begin
        s00_axis_tready = in_load && (grant_q == 1'b0) && fft_axis_tready;
        s01_axis_tready = in_load && (grant_q == 1'b1) && fft_axis_tready;

        fft_axis_tvalid = in_load && sel_vld;
        fft_axis_tdata  = in_load ? sel_dat : '0;
        fft_axis_tlast  = in_load && beat_last;

        fft_start       = (state_q == START);

        fft_res_tready  = in_drain && m00_axis_tready;
        m00_axis_tvalid = in_drain && fft_res_tvalid;
        m00_axis_tdata  = in_drain ? fft_res_tdata : '0;
        m00_axis_tlast  = in_drain && fft_res_tlast;
        m00_axis_tdest  = in_drain ? grant_q[0] : 1'b0;

        busy            = (state_q != IDLE);
        err_len         = err_len_q;
    end

endmodule
